// File: rtl/signed_pow2_divider_pipe.sv
// ---------------------------------------------------------------------------
// signed_pow2_divider_pipe
//   Pipelined signed divide of a W-bit two's-complement operand by 2**shamt.
//   Per transaction the quotient is either floored (arithmetic shift right)
//   or truncated toward zero (C-style '/'). Stage 0 registers the operand with
//   the truncation bias already added; stages 1..SW each resolve one bit of
//   the shift amount. All stages advance together under a single enable, so
//   the block supports full valid/ready backpressure at one result per cycle.
//
//   Optional feature macro: POW2_DIV_REMAINDER_EN
//     defined   : original a and s ride the pipe; out_rem = a - (q << s)
//     undefined : no a/s pipeline copies; out_rem is tied to zero
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : input transaction valid
//   in_ready  : block accepts input this cycle (= global advance)
//   in_a      : dividend, signed
//   in_shamt  : exponent s, divisor = 2**s (s >= W allowed)
//   in_trunc  : 0 = floor, 1 = round toward zero
//   out_valid : result valid
//   out_ready : consumer accepts result
//   out_q     : quotient, signed
//   out_rem   : remainder, signed (zero when the remainder path is disabled)
// ---------------------------------------------------------------------------
module signed_pow2_divider_pipe #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [SW-1:0] in_shamt,
    input  logic          in_trunc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_q,
    output logic [W-1:0]  out_rem
);

    localparam int unsigned LAST_AMT = 1 << (SW - 1);

    // Global advance: every stage moves when the output slot is free or drained.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k holds only the shift-amount bits still to be applied: [SW-1:k].
    genvar k;
    for (k = 0; k < SW; k++) begin : g_stg
        logic          vld;
        logic [W-1:0]  val;
        logic [SW-1:k] shr;
        logic          trn;
        logic          clp;
`ifdef POW2_DIV_REMAINDER_EN
        logic [W-1:0]  a_o;
        logic [SW-1:0] s_o;
`endif

        if (k == 0) begin : g_first
            logic         clamp_c;
            logic [W-1:0] bias_c;

            // Bias of 2**s-1 turns the floor shift into truncation for negative a;
            // suppressed when s >= W, where the final stage forces the result.
            always_comb begin
                clamp_c = (in_shamt >= SW'(W));
                bias_c  = '0;
                if (in_trunc && in_a[W-1] && !clamp_c) begin
                    bias_c = (W'(1) << in_shamt) - W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= 1'b0;
                    val <= '0;
                    shr <= '0;
                    trn <= 1'b0;
                    clp <= 1'b0;
`ifdef POW2_DIV_REMAINDER_EN
                    a_o <= '0;
                    s_o <= '0;
`endif
                end else if (adv) begin
                    vld <= in_valid;
                    val <= in_a + bias_c;
                    shr <= in_shamt;
                    trn <= in_trunc;
                    clp <= clamp_c;
`ifdef POW2_DIV_REMAINDER_EN
                    a_o <= in_a;
                    s_o <= in_shamt;
`endif
                end
            end
        end else begin : g_shift
            localparam int unsigned AMT = 1 << (k - 1);

            // Log-shifter stage: conditional arithmetic shift by 2**(k-1).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= 1'b0;
                    val <= '0;
                    shr <= '0;
                    trn <= 1'b0;
                    clp <= 1'b0;
`ifdef POW2_DIV_REMAINDER_EN
                    a_o <= '0;
                    s_o <= '0;
`endif
                end else if (adv) begin
                    vld <= g_stg[k-1].vld;
                    val <= g_stg[k-1].shr[k-1] ? W'($signed(g_stg[k-1].val) >>> AMT)
                                               : g_stg[k-1].val;
                    shr <= g_stg[k-1].shr[SW-1:k];
                    trn <= g_stg[k-1].trn;
                    clp <= g_stg[k-1].clp;
`ifdef POW2_DIV_REMAINDER_EN
                    a_o <= g_stg[k-1].a_o;
                    s_o <= g_stg[k-1].s_o;
`endif
                end
            end
        end
    end

    // Final stage inputs taken from the last internal stage.
    logic         last_vld;
    logic [W-1:0] last_val;
    logic         last_bit;
    logic         last_trn;
    logic         last_clp;
    assign last_vld = g_stg[SW-1].vld;
    assign last_val = g_stg[SW-1].val;
    assign last_bit = g_stg[SW-1].shr[SW-1];
    assign last_trn = g_stg[SW-1].trn;
    assign last_clp = g_stg[SW-1].clp;

    // Last shift bit, then the s >= W override: sign fill for floor, zero for trunc.
    logic [W-1:0] shift_c;
    logic [W-1:0] q_c;
    always_comb begin
        shift_c = last_bit ? W'($signed(last_val) >>> LAST_AMT) : last_val;
        q_c     = shift_c;
        if (last_clp) begin
            q_c = last_trn ? '0 : {W{last_val[W-1]}};
        end
    end

`ifdef POW2_DIV_REMAINDER_EN
    // Remainder is formed modulo 2**W; q << s vanishes for s >= W so rem = a.
    logic [W-1:0] rem_c;
    always_comb begin
        rem_c = g_stg[SW-1].a_o - W'(q_c << g_stg[SW-1].s_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_rem   <= '0;
        end else if (adv) begin
            out_valid <= last_vld;
            out_q     <= q_c;
            out_rem   <= rem_c;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (adv) begin
            out_valid <= last_vld;
            out_q     <= q_c;
        end
    end

    assign out_rem = '0;
`endif

endmodule

// File: tb/tb_signed_pow2_divider_pipe.sv
// Scoreboard bench for signed_pow2_divider_pipe (W=8, SW=4).
module tb_signed_pow2_divider_pipe;

`ifdef POW2_DIV_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [3:0] in_shamt = '0;
    logic       in_trunc = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_q;
    logic [7:0] out_rem;

    signed_pow2_divider_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_shamt(in_shamt), .in_trunc(in_trunc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_rem(out_rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] rem;
        bit         lat;
        int         tag;
        int         cyc;
    } item_t;

    item_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    rdy_rand = 1'b0;
    bit    rdy_val = 1'b1;
    int    t4_cnt = 0;
    int    t4_first = 0;
    int    t4_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Golden model: '>>>' for floor, '/' for truncation, remainder by multiply.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [3:0] s, input logic t);
        int ai;
        int q;
        int r;
        ai = int'($signed(a));
        if (s >= 4'd8) q = t ? 0 : (ai >>> s);
        else if (t)    q = ai / (1 << s);
        else           q = ai >>> s;
        r = ai - q * (1 << s);
        return {8'(q), 8'(r)};
    endfunction

    // Consumer readiness, changed just after the rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // Monitor: protocol checks and scoreboard pop at the falling edge.
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] pq = '0;
        logic [7:0] pr = '0;
        item_t      it;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_q", 32'(out_q), 32'(pq));
                    chk("stall_rem", 32'(out_rem), 32'(pr));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got q=%0h with empty scoreboard", out_q);
                    end else begin
                        it = sb.pop_front();
                        chk("q", 32'(out_q), 32'(it.q));
                        chk("rem", 32'(out_rem), REM_EN ? 32'(it.rem) : 32'd0);
                        if (it.lat) chk("latency", 32'(cyc - it.cyc), 32'd5);
                        if (it.tag == 4) begin
                            if (t4_cnt == 0) t4_first = cyc;
                            t4_last = cyc;
                            t4_cnt++;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                pq = out_q;
                pr = out_rem;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [3:0] s, input logic t,
                        input logic [7:0] eq, input logic [7:0] er, input bit lat, input int tag);
        item_t it;
        bit    ok = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_shamt = s;
        in_trunc = t;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: a=%0h never accepted", a);
        end else begin
            it.q = eq; it.rem = er; it.lat = lat; it.tag = tag; it.cyc = cyc;
            sb.push_back(it);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [7:0] a, input logic [3:0] s, input logic t, input int tag);
        logic [15:0] m;
        m = model(a, s, t);
        send(a, s, t, m[15:8], m[7:0], 1'b0, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [3:0] s;
        logic       t;
        logic [7:0] q;
        logic [7:0] rem;
    } vec_t;

    // Hand-computed vectors: a, s, trunc, q, rem.
    vec_t dirv[12] = '{
        '{8'hF9, 4'd1,  1'b0, 8'hFC, 8'h01},
        '{8'hF9, 4'd1,  1'b1, 8'hFD, 8'hFF},
        '{8'h80, 4'd7,  1'b0, 8'hFF, 8'h00},
        '{8'h80, 4'd7,  1'b1, 8'hFF, 8'h00},
        '{8'h7F, 4'd3,  1'b0, 8'h0F, 8'h07},
        '{8'h7F, 4'd3,  1'b1, 8'h0F, 8'h07},
        '{8'hA5, 4'd0,  1'b0, 8'hA5, 8'h00},
        '{8'hA5, 4'd0,  1'b1, 8'hA5, 8'h00},
        '{8'h80, 4'd9,  1'b0, 8'hFF, 8'h80},
        '{8'h80, 4'd9,  1'b1, 8'h00, 8'h80},
        '{8'h05, 4'd15, 1'b0, 8'h00, 8'h05},
        '{8'h05, 4'd15, 1'b1, 8'h00, 8'h05}
    };

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_q", 32'(out_q), 32'd0);
        chk("reset_out_rem", 32'(out_rem), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // Scenario 1: latency of an isolated transaction in both modes.
        send(dirv[0].a, dirv[0].s, dirv[0].t, dirv[0].q, dirv[0].rem, 1'b1, 1);
        drain();
        send(dirv[1].a, dirv[1].s, dirv[1].t, dirv[1].q, dirv[1].rem, 1'b1, 1);
        drain();

        // Scenarios 2-3: boundary vectors back to back.
        for (int i = 2; i < 12; i++)
            send(dirv[i].a, dirv[i].s, dirv[i].t, dirv[i].q, dirv[i].rem, 1'b0, 2);
        drain();

        // Scenario 4: 20 back-to-back random inputs with out_ready held high.
        for (int i = 0; i < 20; i++)
            send_model(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4);
        drain();
        chk("t4_count", 32'(t4_cnt), 32'd20);
        chk("t4_one_per_cycle", 32'(t4_last - t4_first), 32'd19);

        // Scenario 5: random backpressure and random input gaps.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send_model(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 5);
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        drain();

        // Scenario 6: asynchronous reset with three transactions in flight.
        rdy_val = 1'b0;
        idle(1);
        for (int i = 0; i < 3; i++) send_model(8'h10 + 8'(i), 4'd1, 1'b0, 6);
        idle(8);
        chk("stalled_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rdy_val = 1'b1;
        idle(1);
        send(8'hF0, 4'd2, 1'b0, 8'hFC, 8'h00, 1'b0, 6);
        drain();
        idle(3);
        chk("no_extra_after_reset", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
